// File: rtl/io_mbx_pkg.sv
// io_mbx_pkg
// Shared constants for the port I/O mailbox responder.
//   - Bit positions inside the processor control word (pCtl_i).
//   - Bit positions inside the status word (pStat_o).
//   - LSBs and width of the two count fields in pStat_o.
//   - State encoding of the up-direction presentation FSM.
package io_mbx_pkg;

  // Control word bits written by the processor
  localparam int DN_REQ_BIT  = 0;
  localparam int UP_ACK_BIT  = 1;

  // Status word bits read by the processor
  localparam int DN_ACK_BIT  = 0;
  localparam int UP_REQ_BIT  = 1;
  localparam int DN_FULL_BIT = 2;
  localparam int UP_PEND_BIT = 3;
  localparam int DN_CNT_LSB  = 4;
  localparam int UP_CNT_LSB  = 8;
  localparam int CNT_FIELD_W = 4;

  // Up-direction FSM: IDLE looks for a word to present,
  // WAIT holds it until the processor echoes UP_REQ on UP_ACK
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } up_state_t;

endpackage

// File: rtl/io_mbx_fifo.sv
// io_mbx_fifo
// Small synchronous FIFO used once per mailbox direction.
// Ports:
//   Clk, Rst_n  clock (rising edge) and asynchronous active-low reset
//   push        write push_data at the tail (ignored while full)
//   push_data   word to write
//   pop         drop the head entry (ignored while empty)
//   head        current head word (stale contents while empty)
//   count       number of stored entries, 0..DEPTH
//   full/empty  count == DEPTH / count == 0
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module io_mbx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Storage is cleared on reset so the head reads zero before the first
  // write; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/io_mailbox_responder.sv
// io_mailbox_responder
// Peripheral end of the processor's port I/O channel. Two toggle-handshake
// mailboxes move words down (processor -> peripheral) and up
// (peripheral -> processor), each buffered by an io_mbx_fifo.
// Ports:
//   Clk, Rst_n  clock (rising edge) and asynchronous active-low reset
//   pData_i     processor output data port (down words)
//   pCtl_i      processor output control port: bit0 DN_REQ, bit1 UP_ACK
//   pData_o     processor input data port (presented up word)
//   pStat_o     processor input status port: DN_ACK, UP_REQ, dnFull,
//               upPending, down count [7:4], up count [11:8]
//   rxData/rxValid/rxReady  down stream to the peripheral
//   txData/txValid/txReady  up stream from the peripheral
module io_mailbox_responder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] pData_i,
  input  logic [WIDTH-1:0] pCtl_i,
  output logic [WIDTH-1:0] pData_o,
  output logic [WIDTH-1:0] pStat_o,
  output logic [WIDTH-1:0] rxData,
  output logic             rxValid,
  input  logic             rxReady,
  input  logic [WIDTH-1:0] txData,
  input  logic             txValid,
  output logic             txReady
);

  import io_mbx_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  // Down direction
  logic          dn_prev;
  logic          dn_ack;
  logic          dn_new_req;
  logic          dn_push;
  logic          dn_pop;
  logic          dn_full;
  logic          dn_empty;
  logic [CW-1:0] dn_cnt;

  // Up direction
  logic             up_req;
  logic             up_push;
  logic             up_load;
  logic             up_full;
  logic             up_empty;
  logic [CW-1:0]    up_cnt;
  logic [WIDTH-1:0] up_head;
  up_state_t        up_state;
  up_state_t        up_next;

  logic unused_ctl;
  assign unused_ctl = ^pCtl_i[WIDTH-1:2];

  // A request is taken only while the FIFO has room as seen before this
  // cycle's pop, so a blocked request is simply re-evaluated next cycle.
  assign dn_new_req = (pCtl_i[DN_REQ_BIT] != dn_prev);
  assign dn_push    = dn_new_req & ~dn_full;
  assign dn_pop     = rxValid & rxReady;
  assign rxValid    = ~dn_empty;

  io_mbx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dn_fifo (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .push      (dn_push),
    .push_data (pData_i),
    .pop       (dn_pop),
    .head      (rxData),
    .count     (dn_cnt),
    .full      (dn_full),
    .empty     (dn_empty)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dn_prev <= 1'b0;
      dn_ack  <= 1'b0;
    end else if (dn_push) begin
      dn_prev <= pCtl_i[DN_REQ_BIT];
      dn_ack  <= ~dn_ack;
    end
  end

  assign txReady = ~up_full;
  assign up_push = txValid & txReady;

  io_mbx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_up_fifo (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .push      (up_push),
    .push_data (txData),
    .pop       (up_load),
    .head      (up_head),
    .count     (up_cnt),
    .full      (up_full),
    .empty     (up_empty)
  );

  // Presentation FSM: the ack edge returns to IDLE and the reload happens
  // on the following edge, giving the two-cycle minimum word spacing.
  always_comb begin
    up_next = up_state;
    up_load = 1'b0;
    case (up_state)
      IDLE: begin
        if (!up_empty) begin
          up_load = 1'b1;
          up_next = WAIT;
        end
      end
      WAIT: begin
        if (pCtl_i[UP_ACK_BIT] == up_req) begin
          up_next = IDLE;
        end
      end
      default: up_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      up_state <= IDLE;
      up_req   <= 1'b0;
      pData_o  <= '0;
    end else begin
      up_state <= up_next;
      if (up_load) begin
        pData_o <= up_head;
        up_req  <= ~up_req;
      end
    end
  end

  // Status is assembled purely from registered state, never from inputs.
  always_comb begin
    pStat_o                                = '0;
    pStat_o[DN_ACK_BIT]                    = dn_ack;
    pStat_o[UP_REQ_BIT]                    = up_req;
    pStat_o[DN_FULL_BIT]                   = dn_full;
    pStat_o[UP_PEND_BIT]                   = (up_state == WAIT);
    pStat_o[DN_CNT_LSB +: CNT_FIELD_W]     = CNT_FIELD_W'(dn_cnt);
    pStat_o[UP_CNT_LSB +: CNT_FIELD_W]     = CNT_FIELD_W'(up_cnt);
  end

endmodule

// File: tb/tb_io_mailbox_responder.sv
// tb_io_mailbox_responder
// Bench acting as the processor and the peripheral around the mailbox.
// A queue-based model of the mailbox rules is compared against the DUT on
// every falling edge; directed sequences add hand-computed literal checks.
module tb_io_mailbox_responder;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic [WIDTH-1:0] pData_i = '0;
  logic [WIDTH-1:0] pCtl_i = '0;
  logic [WIDTH-1:0] pData_o;
  logic [WIDTH-1:0] pStat_o;
  logic [WIDTH-1:0] rxData;
  logic             rxValid;
  logic             rxReady = 1'b0;
  logic [WIDTH-1:0] txData = '0;
  logic             txValid = 1'b0;
  logic             txReady;

  int nChecks = 0;
  int nPass = 0;

  // Processor-side toggle state driven by the bench
  logic procDnReq = 1'b0;
  logic procUpAck = 1'b0;

  // Behavioural model
  logic [WIDTH-1:0] dnQ[$];
  logic [WIDTH-1:0] upQ[$];
  logic             mDnPrev = 1'b0;
  logic             mDnAck = 1'b0;
  logic             mUpReq = 1'b0;
  logic             mWait = 1'b0;
  logic [WIDTH-1:0] mPData = '0;
  logic             mDnPush;
  logic             mDnPop;
  logic             mUpPush;

  logic [WIDTH-1:0] words [5];

  io_mailbox_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .pData_i (pData_i),
    .pCtl_i  (pCtl_i),
    .pData_o (pData_o),
    .pStat_o (pStat_o),
    .rxData  (rxData),
    .rxValid (rxValid),
    .rxReady (rxReady),
    .txData  (txData),
    .txValid (txValid),
    .txReady (txReady)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual === expected) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic setCtl(input logic [WIDTH-3:0] upper);
    pCtl_i = {upper, procUpAck, procDnReq};
  endtask

  function automatic logic [WIDTH-1:0] expStat();
    logic [WIDTH-1:0] s;
    s       = '0;
    s[0]    = mDnAck;
    s[1]    = mUpReq;
    s[2]    = (dnQ.size() == DEPTH);
    s[3]    = mWait;
    s[7:4]  = 4'(dnQ.size());
    s[11:8] = 4'(upQ.size());
    return s;
  endfunction

  // Model update: each edge takes pending work from the queues using the
  // pre-edge sizes; reset empties everything immediately.
  initial begin
    forever begin
      @(posedge Clk or negedge Rst_n);
      if (!Rst_n) begin
        dnQ.delete();
        upQ.delete();
        mDnPrev = 1'b0;
        mDnAck  = 1'b0;
        mUpReq  = 1'b0;
        mWait   = 1'b0;
        mPData  = '0;
      end else begin
        mDnPop  = (dnQ.size() > 0) && rxReady;
        mDnPush = (pCtl_i[0] != mDnPrev) && (dnQ.size() < DEPTH);
        mUpPush = txValid && (upQ.size() < DEPTH);
        if (mDnPop) void'(dnQ.pop_front());
        if (mDnPush) begin
          dnQ.push_back(pData_i);
          mDnPrev = pCtl_i[0];
          mDnAck  = ~mDnAck;
        end
        if (!mWait) begin
          if (upQ.size() > 0) begin
            mPData = upQ.pop_front();
            mUpReq = ~mUpReq;
            mWait  = 1'b1;
          end
        end else if (pCtl_i[1] == mUpReq) begin
          mWait = 1'b0;
        end
        if (mUpPush) upQ.push_back(txData);
      end
    end
  end

  // Compare process: every falling edge, DUT outputs against the model
  initial begin
    forever begin
      @(negedge Clk);
      checkOutput("pStat", 32'(pStat_o), 32'(expStat()));
      checkOutput("pData_o", 32'(pData_o), 32'(mPData));
      checkOutput("rxValid", 32'(rxValid), 32'(dnQ.size() > 0));
      checkOutput("txReady", 32'(txReady), 32'(upQ.size() < DEPTH));
      if (dnQ.size() > 0) begin
        checkOutput("rxData", 32'(rxData), 32'(dnQ[0]));
      end
    end
  end

  // One randomized cycle: processor and peripheral behave legally
  task automatic applyStimulus(input int rxPct);
    rxReady = ($urandom_range(0, 99) < rxPct);
    txValid = $urandom_range(0, 1) == 1;
    txData  = WIDTH'($urandom);
    if (mDnAck == procDnReq && $urandom_range(0, 2) == 0) begin
      pData_i   = WIDTH'($urandom);
      procDnReq = ~procDnReq;
    end
    if (mWait && mUpReq != procUpAck && $urandom_range(0, 1) == 1) begin
      procUpAck = mUpReq;
    end
    setCtl((WIDTH-2)'($urandom));
    step();
  endtask

  initial begin
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;
    words[3] = 16'h4444;
    words[4] = 16'h5555;

    // Reset state
    #3;
    checkOutput("rst pStat", 32'(pStat_o), 32'h0);
    checkOutput("rst pData_o", 32'(pData_o), 32'h0);
    checkOutput("rst rxValid", 32'(rxValid), 32'h0);
    checkOutput("rst rxData", 32'(rxData), 32'h0);
    checkOutput("rst txReady", 32'(txReady), 32'h1);
    step(2);
    Rst_n = 1'b1;
    step(3);
    checkOutput("post-rst pStat", 32'(pStat_o), 32'h0);

    // Single down word
    pData_i   = 16'hA5A5;
    procDnReq = 1'b1;
    setCtl('0);
    step();
    checkOutput("dn1 ack", 32'(pStat_o[0]), 32'h1);
    checkOutput("dn1 rxValid", 32'(rxValid), 32'h1);
    checkOutput("dn1 rxData", 32'(rxData), 32'hA5A5);
    checkOutput("dn1 count", 32'(pStat_o[7:4]), 32'h1);
    rxReady = 1'b1;
    step();
    rxReady = 1'b0;
    checkOutput("dn1 drained", 32'(pStat_o[7:4]), 32'h0);

    // Fill the down FIFO, then hold a fifth request off
    for (int i = 0; i < 4; i++) begin
      pData_i   = words[i];
      procDnReq = ~procDnReq;
      setCtl('0);
      step();
    end
    checkOutput("full flag", 32'(pStat_o[2]), 32'h1);
    checkOutput("full count", 32'(pStat_o[7:4]), 32'h4);
    checkOutput("full ack", 32'(pStat_o[0]), 32'h1);
    pData_i   = words[4];
    procDnReq = ~procDnReq;
    setCtl('0);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("blocked ack", 32'(pStat_o[0]), 32'h1);
    end
    checkOutput("head before pulse", 32'(rxData), 32'(words[0]));
    rxReady = 1'b1;
    step();
    rxReady = 1'b0;
    checkOutput("pop-cycle ack", 32'(pStat_o[0]), 32'h1);
    checkOutput("pop-cycle count", 32'(pStat_o[7:4]), 32'h3);
    step();
    checkOutput("retry ack", 32'(pStat_o[0]), 32'h0);
    checkOutput("retry count", 32'(pStat_o[7:4]), 32'h4);
    rxReady = 1'b1;
    for (int i = 1; i < 5; i++) begin
      checkOutput("rx order", 32'(rxData), 32'(words[i]));
      step();
    end
    rxReady = 1'b0;
    checkOutput("dn drained", 32'(rxValid), 32'h0);

    // Up single word and backlog
    txData  = 16'h1234;
    txValid = 1'b1;
    step();
    txValid = 1'b0;
    step();
    checkOutput("up1 pData", 32'(pData_o), 32'h1234);
    checkOutput("up1 req", 32'(pStat_o[1]), 32'h1);
    checkOutput("up1 pend", 32'(pStat_o[3]), 32'h1);
    txData  = 16'h5678;
    txValid = 1'b1;
    step();
    txValid = 1'b0;
    checkOutput("backlog hold", 32'(pData_o), 32'h1234);
    checkOutput("backlog count", 32'(pStat_o[11:8]), 32'h1);
    procUpAck = 1'b1;
    setCtl('0);
    step();
    checkOutput("ack idle", 32'(pStat_o[3]), 32'h0);
    checkOutput("ack hold", 32'(pData_o), 32'h1234);
    step();
    checkOutput("up2 pData", 32'(pData_o), 32'h5678);
    checkOutput("up2 req", 32'(pStat_o[1]), 32'h0);
    checkOutput("up2 pend", 32'(pStat_o[3]), 32'h1);
    procUpAck = 1'b0;
    setCtl('0);
    step();
    checkOutput("up2 acked", 32'(pStat_o[3]), 32'h0);

    // Reset in mid-operation
    for (int i = 0; i < 2; i++) begin
      pData_i   = words[i];
      procDnReq = ~procDnReq;
      setCtl('0);
      step();
    end
    txValid = 1'b1;
    for (int i = 2; i < 5; i++) begin
      txData = words[i];
      step();
    end
    txValid = 1'b0;
    checkOutput("pre-rst dn count", 32'(pStat_o[7:4]), 32'h2);
    checkOutput("pre-rst up count", 32'(pStat_o[11:8]), 32'h2);
    checkOutput("pre-rst pData", 32'(pData_o), 32'(words[2]));
    procDnReq = 1'b0;
    procUpAck = 1'b0;
    setCtl('0);
    Rst_n = 1'b0;
    #1;
    checkOutput("mid-rst pStat", 32'(pStat_o), 32'h0);
    checkOutput("mid-rst pData", 32'(pData_o), 32'h0);
    checkOutput("mid-rst rxValid", 32'(rxValid), 32'h0);
    step(2);
    Rst_n = 1'b1;
    step(3);
    checkOutput("post mid-rst pStat", 32'(pStat_o), 32'h0);
    checkOutput("post mid-rst pData", 32'(pData_o), 32'h0);

    // Randomized traffic with slow, balanced and fast peripherals
    for (int i = 0; i < 600; i++) applyStimulus(10);
    for (int i = 0; i < 600; i++) applyStimulus(50);
    for (int i = 0; i < 600; i++) applyStimulus(90);

    rxReady = 1'b0;
    txValid = 1'b0;
    step(2);
    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
